// File: rtl/guess_game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | guess_game_pkg                                                     |
// | Shared state encoding, colour constants and LFSR settings.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package guess_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_CMP  = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_t;

    localparam logic [2:0] c_RGB_BLACK  = 3'b000;
    localparam logic [2:0] c_RGB_BLUE   = 3'b001;
    localparam logic [2:0] c_RGB_GREEN  = 3'b010;
    localparam logic [2:0] c_RGB_RED    = 3'b100;
    localparam logic [2:0] c_RGB_YELLOW = 3'b110;
    localparam logic [2:0] c_RGB_WHITE  = 3'b111;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, state shifted right.
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] c_LFSR_TAPS = 16'h002D;

    function automatic logic [3:0] lfsr_digit(input logic [3:0] i_nib);
        return (i_nib > 4'd9) ? (i_nib - 4'd6) : i_nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/guess_score.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | guess_score                                                        |
// | Combinational exact (A) and misplaced (B) digit match counter.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module guess_score #(
    parameter int NDIGIT = 3,
    parameter int CW     = $clog2(NDIGIT + 1)
) (
    input  logic [4*NDIGIT-1:0] i_guess,
    input  logic [4*NDIGIT-1:0] i_secret,
    output logic [CW-1:0]       o_a,
    output logic [CW-1:0]       o_b
);

    logic [3:0] w_g [NDIGIT];
    logic [3:0] w_s [NDIGIT];
    logic       w_found;

    for (genvar k = 0; k < NDIGIT; k++) begin : g_unpack
        assign w_g[k] = i_guess[4*k +: 4];
        assign w_s[k] = i_secret[4*k +: 4];
    end

    // A digit counts as misplaced if it appears at some other unmatched secret position.
    always_comb begin
        o_a     = '0;
        o_b     = '0;
        w_found = 1'b0;
        for (int i = 0; i < NDIGIT; i++) begin
            w_found = 1'b0;
            for (int j = 0; j < NDIGIT; j++) begin
                if ((w_g[i] == w_s[j]) && (w_g[j] != w_s[j]))
                    w_found = 1'b1;
            end
            if (w_g[i] == w_s[i])
                o_a = o_a + CW'(1);
            else if (w_found)
                o_b = o_b + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/guess_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | guess_game_ctrl                                                    |
// | Number-guessing game FSM with A/B scoring and pixel overlay.       |
// | Option macro GUESS_LFSR_EN: secret drawn from internal LFSR.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int NDIGIT  = 3,
    parameter int MAX_TRY = 8,
    parameter int BAR_W   = 16,
    parameter int HX0     = 200,
    parameter int HY0     = 100,
    parameter int HX1     = 440,
    parameter int HY1     = 140,
    parameter int PX0     = 200,
    parameter int PY0     = 300,
    parameter int PX1     = 440,
    parameter int PY1     = 340
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    pix_x,
    input  logic [9:0]                    pix_y,
    input  logic [4*NDIGIT-1:0]           iNum,
    input  logic                          iNumRdy,
    input  logic                          iStart,
    input  logic [4*NDIGIT-1:0]           iSecret,
    output logic [$clog2(NDIGIT+1)-1:0]   oA,
    output logic [$clog2(NDIGIT+1)-1:0]   oB,
    output logic [3:0]                    oTries,
    output logic [2:0]                    oState,
    output logic                          oBad,
    output logic                          hint_on,
    output logic                          play_on,
    output logic                          rgb_on,
    output logic [2:0]                    out_rgb
);

    localparam int CW = $clog2(NDIGIT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [4*NDIGIT-1:0] r_secret;
    logic [4*NDIGIT-1:0] r_guess;
    logic [4*NDIGIT-1:0] w_secret_src;
    logic [CW-1:0]       r_a;
    logic [CW-1:0]       r_b;
    logic [CW-1:0]       w_a;
    logic [CW-1:0]       w_b;
    logic [3:0]          r_tries;
    logic [3:0]          w_tries_inc;
    logic                r_bad;
    logic                w_bad;

`ifdef GUESS_LFSR_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_lfsr <= c_LFSR_SEED;
        else
            r_lfsr <= {^(r_lfsr & c_LFSR_TAPS), r_lfsr[15:1]};
    end

    // Digits beyond the fourth reuse the LFSR nibbles cyclically.
    for (genvar k = 0; k < NDIGIT; k++) begin : g_lfsr_digit
        assign w_secret_src[4*k +: 4] = lfsr_digit(r_lfsr[4*(k%4) +: 4]);
    end
`else
    assign w_secret_src = iSecret;
`endif

    guess_score #(
        .NDIGIT (NDIGIT),
        .CW     (CW)
    ) u_score (
        .i_guess  (r_guess),
        .i_secret (r_secret),
        .o_a      (w_a),
        .o_b      (w_b)
    );

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIGIT; i++) begin
            if (iNum[4*i +: 4] > 4'd9)
                w_bad = 1'b1;
        end
    end

    assign w_tries_inc = (r_tries == 4'(MAX_TRY)) ? r_tries : (r_tries + 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (iStart)
                    w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (iNumRdy && !w_bad)
                    w_next = ST_CMP;
            end
            ST_CMP: begin
                if (w_a == CW'(NDIGIT))
                    w_next = ST_WIN;
                else if (w_tries_inc == 4'(MAX_TRY))
                    w_next = ST_LOSE;
                else
                    w_next = ST_WAIT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_secret <= '0;
            r_guess  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_tries  <= '0;
            r_bad    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (iStart) begin
                        r_secret <= w_secret_src;
                        r_a      <= '0;
                        r_b      <= '0;
                        r_tries  <= '0;
                        r_bad    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (iNumRdy) begin
                        r_bad <= w_bad;
                        if (!w_bad)
                            r_guess <= iNum;
                    end
                end
                ST_CMP: begin
                    r_a     <= w_a;
                    r_b     <= w_b;
                    r_tries <= w_tries_inc;
                end
                default: ;
            endcase
        end
    end

    assign oA     = r_a;
    assign oB     = r_b;
    assign oTries = r_tries;
    assign oState = r_state;
    assign oBad   = r_bad;

    logic [31:0] w_px;
    logic [31:0] w_py;
    logic [31:0] w_bar_end;
    logic        w_hint;
    logic        w_play;
    logic [2:0]  w_rgb;
    logic        r_hint_on;
    logic        r_play_on;
    logic        r_rgb_on;
    logic [2:0]  r_rgb;

    assign w_px      = {22'd0, pix_x};
    assign w_py      = {22'd0, pix_y};
    assign w_bar_end = 32'(PX0) + 32'(r_tries) * 32'(BAR_W);
    assign w_hint    = (w_px >= 32'(HX0)) && (w_px <= 32'(HX1)) &&
                       (w_py >= 32'(HY0)) && (w_py <= 32'(HY1));
    assign w_play    = (w_px >= 32'(PX0)) && (w_px <= 32'(PX1)) &&
                       (w_py >= 32'(PY0)) && (w_py <= 32'(PY1));

    always_comb begin
        w_rgb = c_RGB_BLACK;
        if (w_hint) begin
            case (r_state)
                ST_IDLE: w_rgb = c_RGB_WHITE;
                ST_WIN:  w_rgb = c_RGB_GREEN;
                ST_LOSE: w_rgb = c_RGB_RED;
                default: w_rgb = c_RGB_YELLOW;
            endcase
        end else if (w_play && (w_px < w_bar_end)) begin
            w_rgb = c_RGB_BLUE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hint_on <= 1'b0;
            r_play_on <= 1'b0;
            r_rgb_on  <= 1'b0;
            r_rgb     <= c_RGB_BLACK;
        end else begin
            r_hint_on <= w_hint;
            r_play_on <= w_play;
            r_rgb_on  <= w_hint | w_play;
            r_rgb     <= w_rgb;
        end
    end

    assign hint_on = r_hint_on;
    assign play_on = r_play_on;
    assign rgb_on  = r_rgb_on;
    assign out_rgb = r_rgb;

endmodule
`default_nettype wire

// File: doc/guess_game_ctrl.md
GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 Parameter NDIGIT, default 3, number of BCD digits per guess/secret (legal 2..6).
REQ-002 Parameter MAX_TRY, default 8, guesses allowed before loss (legal 1..15).
REQ-003 Parameter BAR_W, default 16, pixel width of one tries-bar segment.
REQ-004 Parameters HX0,HY0,HX1,HY1 (default 200,100,440,140) hint rectangle; PX0,PY0,PX1,PY1 (default 200,300,440,340) play rectangle; inclusive bounds.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 pix_x  in  10  current pixel column.
REQ-008 pix_y  in  10  current pixel row.
REQ-009 iNum  in  4*NDIGIT  guess digits, digit 0 at LSBs.
REQ-010 iNumRdy  in  1  one-cycle guess-valid strobe.
REQ-011 iStart  in  1  one-cycle new-game strobe.
REQ-012 iSecret  in  4*NDIGIT  externally supplied secret.
REQ-013 oA  out  CW=$clog2(NDIGIT+1)  exact-position matches of last guess.
REQ-014 oB  out  CW  misplaced-digit matches of last guess.
REQ-015 oTries  out  4  guesses consumed.
REQ-016 oState  out  3  FSM state encoding.
REQ-017 oBad  out  1  last strobed guess rejected (digit >9).
REQ-018 hint_on, play_on, rgb_on  out  1 each  pixel inside hint / play / either region.
REQ-019 out_rgb  out  3  pixel colour {R,G,B}.

Function
REQ-020 FSM states SHALL be IDLE=0, WAIT=1, CMP=2, WIN=3, LOSE=4.
REQ-021 iStart in IDLE/WIN/LOSE SHALL latch the secret, clear oTries/oA/oB/oBad, enter WAIT; iStart in WAIT/CMP is ignored.
REQ-022 iNumRdy SHALL be sampled only in WAIT; elsewhere ignored; iStart and iNumRdy together in WAIT: iNumRdy wins.
REQ-023 Guess with any digit >9 SHALL set oBad=1, not consume a try, remain in WAIT.
REQ-024 Valid guess SHALL be registered, set oBad=0, enter CMP; oA/oB/oTries update on exit from CMP (two cycles after strobe).
REQ-025 oA = count of i with guess[i]==secret[i].
REQ-026 oB = count of i with guess[i]!=secret[i] and some j with guess[i]==secret[j] and guess[j]!=secret[j].
REQ-027 CMP exit: oA==NDIGIT -> WIN; else oTries==MAX_TRY after increment -> LOSE; else WAIT.
REQ-028 oTries SHALL saturate at MAX_TRY.
REQ-029 hint_on/play_on/rgb_on/out_rgb SHALL be registered, one cycle after pix_x/pix_y.
REQ-030 Hint region colour: WIN green 010, LOSE red 100, otherwise yellow 110; IDLE white 111.
REQ-031 Play region: blue 001 where pix_x < PX0+oTries*BAR_W, else black 000.
REQ-032 Priority hint > play > background 000; rgb_on = hint_on|play_on.

Reset
REQ-033 reset low SHALL force IDLE, all outputs 0, secret 0, at any time incl. mid-CMP.

Configuration
REQ-034 GUESS_LFSR_EN defined: secret from free-running 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1), digit = nibble, values 10..15 mapped minus 6, iSecret ignored; undefined: iSecret used, no LFSR.

Structure
REQ-035 Package guess_game_pkg SHALL hold state enum, colour constants, LFSR seed/taps.
REQ-036 Sub-module guess_score (combinational A/B count) SHALL be instantiated once.

Verification
REQ-037 Secret 123, guess 123 -> oA=3,oB=0, state WIN, hint green.
REQ-038 Secret 123, guess 312 -> oA=0,oB=3, oTries=1, WAIT.
REQ-039 Secret 112, guess 211 -> oA=1,oB=2.
REQ-040 Guess digit 12 -> oBad=1, oTries unchanged, WAIT.
REQ-041 MAX_TRY=8 wrong guesses -> LOSE, hint red, play bar 8*BAR_W blue; iNumRdy then ignored.
REQ-042 reset asserted during CMP -> IDLE, all outputs 0 same cycle.
